bit_pair_packer: RTL and testbench
==================================

Name: bit_pair_packer

Overview:
- Packs a stream of 2-bit symbol pairs into 16-bit words, one pair per accepted cycle, MSB-first.
- Pair 0 of a word lands in out_data[15:14] and pair 7 in out_data[1:0], so that input_buffer splits the word back into the same pair order.
- Sits at the encoder/channel side of the Viterbi datapath; feeds the word interface consumed by input_buffer.
- Valid/ready handshakes on both sides, one-word output holding register, flush for partial words.

Parameters:
- PAIRS_PER_WORD, 8: pairs per output word; the output word is 2*PAIRS_PER_WORD bits (16 at default).
- PAD_VALUE, 2'b00: value written into unfilled pair slots on flush.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_pair  input  2  next bit pair.
- in_valid  input  1  in_pair is valid this cycle.
- in_flush  input  1  close the current partial word; qualified by in_ready.
- in_ready  output  1  packer accepts in_pair/in_flush this cycle.
- out_data  output  16  packed word (2*PAIRS_PER_WORD).
- out_pairs  output  4  number of valid pairs in out_data (1..PAIRS_PER_WORD).
- out_partial  output  1  word was closed by flush (out_pairs < PAIRS_PER_WORD).
- out_valid  output  1  output word valid.
- out_ready  input  1  downstream accepts the word.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: assembly register = 0, pair count = 0, out_data = 0, out_pairs = 0, out_partial = 0, out_valid = 0. in_ready is forced 0 while rst is high.
- in_ready = !out_valid || out_ready (combinational). No combinational path from in_valid to out_valid.
- Pair accept: in_valid && in_ready. The pair is written to slot [count], i.e. bits [2*(P-1-count)+1 : 2*(P-1-count)], where P = PAIRS_PER_WORD. count then increments.
- Word completion on accepting slot P-1:
  - Next cycle: out_data = full word, out_pairs = P, out_partial = 0, out_valid = 1.
  - count returns to 0 and the assembly register clears to 0.
  - Latency from the last pair accepted to out_valid is 1 cycle.
- Flush accept: in_flush && in_ready.
  - If count > 0 (after counting any pair accepted the same cycle): the word is emitted next cycle with unfilled slots set to PAD_VALUE, out_pairs = count, out_partial = 1.
  - Flush with count == 0 emits nothing.
  - Flush in the same cycle as the pair that fills slot P-1: one full word is emitted, out_partial = 0, and no empty word follows.
  - Pair and flush in the same cycle: the pair is stored first, then the flush applies.
- Output handshake:
  - out_valid && out_ready consumes the word.
  - If a new word completes in the same cycle, out_valid stays 1 and the new word is loaded, giving zero-bubble throughput of 1 pair/cycle.
  - If no new word completes, out_valid drops to 0.
  - While out_valid && !out_ready: out_data, out_pairs and out_partial stay stable; in_ready = 0; count and assembly contents are held.
- Pairs presented with in_ready = 0 are not consumed; the source holds them.
- Reset mid-word: the partial word and any pending output word are discarded; no output follows reset until P new pairs (or a flush) are accepted.

Optional Feature:
- Macro: PACKER_WORD_CNT_EN.
- Defined: adds output port word_cnt, 16 bits.
  - Increments on each out_valid && out_ready; wraps 0xFFFF to 0x0000.
  - Reset to 0.
  - Counts partial words too.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset 100 ns, out_ready = 1, 8 pairs of 2'b11 back-to-back -> one cycle after the 8th pair: out_data = 16'hFFFF, out_pairs = 8, out_partial = 0, out_valid for 1 cycle.
- Pairs 10 ×8, then 00,01,00,10,00,11,01,00 contiguous -> words 16'hAAAA then 16'h1234 on consecutive word boundaries, in_ready held at 1 throughout.
- out_ready = 0, pairs 01,01,01,10,01,11,10,00 -> out_data = 16'h5678 holds with out_valid = 1, in_ready = 0. Extra pairs are not consumed. Raising out_ready releases the word, then in_ready = 1.
- Pairs 11,01,10, then in_flush -> out_data = 16'hD800, out_pairs = 3, out_partial = 1. A second flush with count == 0 produces no word.
- Assert rst after 5 pairs of a word -> all outputs 0 asynchronously. After release, 8 pairs of 11 give exactly 16'hFFFF with no leftover slots.
- With PACKER_WORD_CNT_EN defined: 3 accepted words -> word_cnt = 3. Preload near 0xFFFF and consume 2 words -> wrap to 0x0001.

Source files
------------

// File: rtl/bit_pair_packer.sv
// Packs 2-bit symbol pairs MSB-first into words with a one-word output register and flush.
// Optional macro PACKER_WORD_CNT_EN adds a 16-bit consumed-word counter port (word_cnt).
module bit_pair_packer #(
  parameter int unsigned PAIRS_PER_WORD = 8,
  parameter logic [1:0]  PAD_VALUE      = 2'b00,
  localparam int unsigned W  = 2 * PAIRS_PER_WORD,
  localparam int unsigned CW = $clog2(PAIRS_PER_WORD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    in_pair,
  input  logic          in_valid,
  input  logic          in_flush,
  output logic          in_ready,
  output logic [W-1:0]  out_data,
  output logic [CW-1:0] out_pairs,
  output logic          out_partial,
  output logic          out_valid,
  input  logic          out_ready
`ifdef PACKER_WORD_CNT_EN
  ,
  output logic [15:0]   word_cnt
`endif
);

  logic [W-1:0]  asm_q, asm_d, asm_ins, padded;
  logic [CW-1:0] count_q, count_d, cnt_after;
  logic [W-1:0]  out_data_q;
  logic [CW-1:0] out_pairs_q;
  logic          out_partial_q, out_valid_q;
  logic          accept_pair, accept_flush, word_full, emit;

  assign in_ready = !rst && (!out_valid_q || out_ready);

  always_comb begin
    accept_pair  = in_valid && in_ready;
    accept_flush = in_flush && in_ready;
    asm_ins      = asm_q;
    for (int unsigned i = 0; i < PAIRS_PER_WORD; i++) begin
      if (accept_pair && count_q == CW'(i))
        asm_ins[2*(PAIRS_PER_WORD-1-i) +: 2] = in_pair;
    end
    cnt_after = count_q + CW'(accept_pair);
    word_full = accept_pair && (count_q == CW'(PAIRS_PER_WORD - 1));
    emit      = word_full || (accept_flush && cnt_after != '0);
    // Slots at or beyond the post-accept count are padding; a full word has none.
    padded = asm_ins;
    for (int unsigned i = 0; i < PAIRS_PER_WORD; i++) begin
      if (CW'(i) >= cnt_after)
        padded[2*(PAIRS_PER_WORD-1-i) +: 2] = PAD_VALUE;
    end
    asm_d   = emit ? '0 : asm_ins;
    count_d = emit ? '0 : cnt_after;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_q         <= '0;
      count_q       <= '0;
      out_data_q    <= '0;
      out_pairs_q   <= '0;
      out_partial_q <= 1'b0;
      out_valid_q   <= 1'b0;
    end else begin
      asm_q   <= asm_d;
      count_q <= count_d;
      if (emit) begin
        out_data_q    <= padded;
        out_pairs_q   <= cnt_after;
        out_partial_q <= !word_full;
        out_valid_q   <= 1'b1;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data    = out_data_q;
  assign out_pairs   = out_pairs_q;
  assign out_partial = out_partial_q;
  assign out_valid   = out_valid_q;

`ifdef PACKER_WORD_CNT_EN
  logic [15:0] word_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      word_cnt_q <= '0;
    else if (out_valid_q && out_ready)
      word_cnt_q <= word_cnt_q + 16'd1;
  end

  assign word_cnt = word_cnt_q;
`endif

endmodule

// File: tb/tb_bit_pair_packer.sv
// Directed self-checking bench for bit_pair_packer with hand-computed expected words.
module tb_bit_pair_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_pair;
  logic        in_valid, in_flush, in_ready;
  logic [15:0] out_data;
  logic [3:0]  out_pairs;
  logic        out_partial, out_valid, out_ready;
`ifdef PACKER_WORD_CNT_EN
  logic [15:0] word_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  bit_pair_packer #(.PAIRS_PER_WORD(8), .PAD_VALUE(2'b00)) dut (
    .clk(clk), .rst(rst), .in_pair(in_pair), .in_valid(in_valid), .in_flush(in_flush),
    .in_ready(in_ready), .out_data(out_data), .out_pairs(out_pairs),
    .out_partial(out_partial), .out_valid(out_valid), .out_ready(out_ready)
`ifdef PACKER_WORD_CNT_EN
    , .word_cnt(word_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_word(input string tag, input logic [15:0] d, input logic [3:0] p,
                          input logic part);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_data"}, out_data, d);
    chk({tag, "_pairs"}, out_pairs, p);
    chk({tag, "_partial"}, out_partial, part);
  endtask

  logic [1:0] seq2 [16] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                            2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b11, 2'b01, 2'b00};
  logic [1:0] seq3 [8]  = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00};
  logic [1:0] seq4 [3]  = '{2'b11, 2'b01, 2'b10};

  initial begin
    rst = 1'b1; in_pair = '0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b1;
    #100;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_pairs", out_pairs, 0);
    chk("rst_partial", out_partial, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // 8 pairs of 11 -> FFFF for exactly one cycle
    in_valid = 1'b1; in_pair = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) chk("t1_no_early_valid", out_valid, 0);
      step();
    end
    in_valid = 1'b0;
    chk_word("t1", 16'hFFFF, 4'd8, 1'b0);
    step();
    chk("t1_one_cycle", out_valid, 0);

    // Back-to-back words AAAA then 1234
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_pair = seq2[i];
      chk("t2_in_ready", in_ready, 1);
      step();
      if (i == 7) chk_word("t2a", 16'hAAAA, 4'd8, 1'b0);
      if (i == 8) chk("t2_gap", out_valid, 0);
    end
    in_valid = 1'b0;
    chk_word("t2b", 16'h1234, 4'd8, 1'b0);
    step();

    // Backpressure: 5678 held, extra pairs not consumed
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_pair = seq3[i];
      step();
    end
    in_pair = 2'b11;
    for (int i = 0; i < 3; i++) begin
      chk_word("t3_hold", 16'h5678, 4'd8, 1'b0);
      chk("t3_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk("t3_release_ready", in_ready, 1);
    step();
    chk("t3_consumed", out_valid, 0);

    // Partial flush 11,01,10 -> D800, then an empty flush
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_pair = seq4[i];
      step();
    end
    in_valid = 1'b0; in_flush = 1'b1;
    step();
    chk_word("t4_flush", 16'hD800, 4'd3, 1'b1);
    step();
    chk("t4_empty_flush", out_valid, 0);
    in_flush = 1'b0;
    step();
    chk("t4_still_empty", out_valid, 0);

    // Pair and flush in the same cycle -> single-pair partial word
    in_valid = 1'b1; in_flush = 1'b1; in_pair = 2'b10;
    step();
    in_valid = 1'b0; in_flush = 1'b0;
    chk_word("t4_pair_flush", 16'h8000, 4'd1, 1'b1);
    step();

    // Flush with the 8th pair -> one full word, no empty word after
    in_valid = 1'b1; in_pair = 2'b00;
    for (int i = 0; i < 7; i++) step();
    in_pair = 2'b01; in_flush = 1'b1;
    step();
    in_valid = 1'b0; in_flush = 1'b0;
    chk_word("t4_full_flush", 16'h0001, 4'd8, 1'b0);
    step();
    chk("t4_no_extra", out_valid, 0);

    // Reset mid-word discards the partial word
    in_valid = 1'b1; in_pair = 2'b01;
    for (int i = 0; i < 5; i++) step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", out_valid, 0);
    chk("t5_rst_data", out_data, 0);
    chk("t5_rst_in_ready", in_ready, 0);
    step();
    step();
    @(negedge clk);
    rst = 1'b0;
    step();
    in_valid = 1'b1; in_pair = 2'b11;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) chk("t5_no_leftover", out_valid, 0);
      step();
    end
    in_valid = 1'b0;
    chk_word("t5", 16'hFFFF, 4'd8, 1'b0);
    step();

`ifdef PACKER_WORD_CNT_EN
    chk("wc_one", word_cnt, 16'd1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_flush = 1'b1; in_pair = 2'b01;
      step();
      in_valid = 1'b0; in_flush = 1'b0;
      step();
    end
    chk("wc_three", word_cnt, 16'd3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
